// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Types and constants shared by the RV pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage with a single outstanding imem request
//               and a one-entry output slot feeding the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [rv_pipe_pkg::XLEN-1:0]   redirect_pc,
  output logic                           imem_req,
  output logic [rv_pipe_pkg::XLEN-1:0]   imem_addr,
  input  logic                           imem_ready,
  input  logic                           imem_rvalid,
  input  logic [rv_pipe_pkg::XLEN-1:0]   imem_rdata,
  output logic [rv_pipe_pkg::XLEN-1:0]   pc_out,
  output logic [rv_pipe_pkg::XLEN-1:0]   instruction,
  output logic                           fetch_valid
);
  import rv_pipe_pkg::*;

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            discard;
  logic            accept;
  logic [XLEN-1:0] redirect_aligned;

  assign imem_req         = (state == FETCH) && !reset;
  assign imem_addr        = fetch_pc;
  assign accept           = imem_req && imem_ready;
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (accept) state_next = WAIT;
      // A redirect arriving with the response drops it just like a pending discard
      WAIT:  if (imem_rvalid) state_next = (discard || redirect_valid) ? FETCH : FULL;
      FULL:  if (redirect_valid || !stall) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      discard     <= 1'b0;
      pc_out      <= RESET_PC;
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
    end else if (redirect_valid) begin
      fetch_valid <= 1'b0;
      instruction <= NOP_INSTR;
      fetch_pc    <= redirect_aligned;
      case (state)
        FETCH: if (accept) begin
          req_pc  <= fetch_pc;
          discard <= 1'b1;
        end
        WAIT:  discard <= !imem_rvalid;
        default: ;
      endcase
    end else begin
      case (state)
        FETCH: if (accept) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + PC_INCR;
        end
        WAIT: if (imem_rvalid) begin
          discard <= 1'b0;
          if (!discard) begin
            pc_out      <= req_pc;
            instruction <= imem_rdata;
            fetch_valid <= 1'b1;
          end
        end
        FULL: if (!stall) begin
          fetch_valid <= 1'b0;
          instruction <= NOP_INSTR;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
